// File: rtl/stack_seq.sv
// Byte-wide stack sequencer: multi-byte push/pull against an external memory
// page, plus stack-pointer load/adjust. All outputs are registered.
module stack_seq #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter logic [7:0] SP_RESET   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_len,
  input  logic [23:0] cmd_wdata,
  input  logic [7:0]  cmd_disp,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        rsp_valid,
  output logic [23:0] rsp_rdata,
  output logic [7:0]  sp,
  output logic        wrap
);

  typedef enum logic [2:0] {IDLE, PUSH, PULL_INC, PULL_RD, DONE} state_e;
  typedef enum logic [1:0] {OP_PUSH, OP_PULL, OP_LOAD, OP_ADJ} op_e;

  state_e      state_q;
  logic [7:0]  sp_q;
  logic        wrap_q;
  logic [1:0]  idx_q;
  logic [1:0]  len_q;
  logic [23:0] wdata_q;
  logic [23:0] rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        rsp_valid_q;

  logic [1:0]  len_eff;
  logic [7:0]  sp_dec;
  logic [7:0]  sp_inc;

  assign len_eff = (cmd_len == 2'd0) ? 2'd1 : cmd_len;
  assign sp_dec  = sp_q - 8'd1;
  assign sp_inc  = sp_q + 8'd1;

  function automatic logic [7:0] byte_sel(input logic [23:0] w, input logic [1:0] i);
    case (i)
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[7:0];
    endcase
  endfunction

  // NOTE: one sequential block, non-blocking assignments only; every output
  // below is a flop so mem_* stay glitch-free and stable while waiting for ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sp_q        <= SP_RESET;
      wrap_q      <= 1'b0;
      idx_q       <= 2'd0;
      len_q       <= 2'd1;
      wdata_q     <= 24'd0;
      rdata_q     <= 24'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 8'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          len_q   <= len_eff;
          wdata_q <= cmd_wdata;
          case (op_e'(cmd_op))
            OP_PUSH: begin
              state_q     <= PUSH;
              idx_q       <= len_eff - 2'd1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {STACK_PAGE, sp_q};
              mem_wdata_q <= byte_sel(cmd_wdata, len_eff - 2'd1);
            end
            OP_PULL: begin
              state_q <= PULL_INC;
              idx_q   <= 2'd0;
              rdata_q <= 24'd0;
            end
            OP_LOAD: begin
              state_q     <= DONE;
              sp_q        <= cmd_disp;
              wrap_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
            end
            OP_ADJ: begin
              state_q     <= DONE;
              sp_q        <= sp_q + cmd_disp;
              rsp_valid_q <= 1'b1;
            end
          endcase
        end
        PUSH: if (mem_ack) begin
          sp_q <= sp_dec;
          if (sp_q == 8'h00) wrap_q <= 1'b1;
          if (idx_q == 2'd0) begin
            state_q     <= DONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
          end else begin
            idx_q       <= idx_q - 2'd1;
            mem_addr_q  <= {STACK_PAGE, sp_dec};
            mem_wdata_q <= byte_sel(wdata_q, idx_q - 2'd1);
          end
        end
        PULL_INC: begin
          sp_q <= sp_inc;
          if (sp_q == 8'hFF) wrap_q <= 1'b1;
          state_q    <= PULL_RD;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= {STACK_PAGE, sp_inc};
        end
        PULL_RD: if (mem_ack) begin
          case (idx_q)
            2'd0:    rdata_q[7:0]   <= mem_rdata;
            2'd1:    rdata_q[15:8]  <= mem_rdata;
            default: rdata_q[23:16] <= mem_rdata;
          endcase
          mem_req_q <= 1'b0;
          if (idx_q == len_q - 2'd1) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= PULL_INC;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sp        = sp_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: a page-sized memory model with configurable
// ack delay logs every acknowledged access; results go through check().
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_len = 2'd0;
  logic [23:0] cmd_wdata = 24'd0;
  logic [7:0]  cmd_disp = 8'd0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic        rsp_valid;
  logic [23:0] rsp_rdata;
  logic [7:0]  sp;
  logic        wrap;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [256];
  logic [15:0] log_addr [$];
  logic        log_we   [$];
  logic [7:0]  log_data [$];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          stable_err = 0;
  logic [15:0] s_addr;
  logic        s_we;
  logic [7:0]  s_wd;

  stack_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .cmd_disp(cmd_disp),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sp(sp), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after ack_delay waiting cycles, logs acked accesses.
  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        if (wait_cnt == 0) begin
          s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
        end else if ({mem_addr, mem_we, mem_wdata} != {s_addr, s_we, s_wd}) begin
          stable_err++;
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          log_addr.push_back(mem_addr);
          log_we.push_back(mem_we);
          log_data.push_back(mem_we ? mem_wdata : mem[mem_addr[7:0]]);
          if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
          else mem_rdata = mem[mem_addr[7:0]];
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete(); log_we.delete(); log_data.delete();
  endtask

  // Issues one command and returns cycles from acceptance to rsp_valid (-1 on timeout).
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] len,
                         input logic [23:0] wd, input logic [7:0] disp, output int lat);
    clear_log();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_wdata = wd; cmd_disp = disp;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; break; end
    end
  endtask

  task automatic chk_acc(input string tag, input int i, input logic [15:0] a,
                         input logic we, input logic [7:0] d);
    check($sformatf("%s_addr%0d", tag, i), {16'd0, log_addr[i]}, {16'd0, a});
    check($sformatf("%s_we%0d", tag, i), {31'd0, log_we[i]}, {31'd0, we});
    check($sformatf("%s_data%0d", tag, i), {24'd0, log_data[i]}, {24'd0, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    repeat (2) @(negedge clk);
    check("rst_ready_in_reset", {31'd0, cmd_ready}, 32'd1);
    check("rst_req_in_reset", {31'd0, mem_req}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sp", {24'd0, sp}, 32'hFF);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    check("rst_rdata", {8'd0, rsp_rdata}, 32'd0);

    // Push two bytes, highest first, immediate ack.
    run_cmd(2'd0, 2'd2, 24'h001234, 8'h00, lat);
    check("push2_lat", lat, 3);
    check("push2_cnt", log_addr.size(), 2);
    chk_acc("push2", 0, 16'h01FF, 1'b1, 8'h12);
    chk_acc("push2", 1, 16'h01FE, 1'b1, 8'h34);
    check("push2_sp", {24'd0, sp}, 32'hFD);
    @(negedge clk);
    check("push2_pulse_once", {31'd0, rsp_valid}, 32'd0);

    run_cmd(2'd1, 2'd2, 24'h0, 8'h00, lat);
    check("pull2_lat", lat, 5);
    check("pull2_cnt", log_addr.size(), 2);
    chk_acc("pull2", 0, 16'h01FE, 1'b0, 8'h34);
    chk_acc("pull2", 1, 16'h01FF, 1'b0, 8'h12);
    check("pull2_rdata", {8'd0, rsp_rdata}, 32'h001234);
    check("pull2_sp", {24'd0, sp}, 32'hFF);
    check("pull2_wrap", {31'd0, wrap}, 32'd0);

    // Push across 00 -> FF sets wrap; a load clears it.
    run_cmd(2'd2, 2'd0, 24'h0, 8'h00, lat);
    check("load00_lat", lat, 1);
    check("load00_nomem", log_addr.size(), 0);
    run_cmd(2'd0, 2'd1, 24'h0000AB, 8'h00, lat);
    check("pushw_lat", lat, 2);
    check("pushw_cnt", log_addr.size(), 1);
    chk_acc("pushw", 0, 16'h0100, 1'b1, 8'hAB);
    check("pushw_sp", {24'd0, sp}, 32'hFF);
    check("pushw_wrap", {31'd0, wrap}, 32'd1);
    run_cmd(2'd2, 2'd0, 24'h0, 8'h10, lat);
    check("load10_wrap", {31'd0, wrap}, 32'd0);
    check("load10_sp", {24'd0, sp}, 32'h10);

    run_cmd(2'd3, 2'd0, 24'h0, 8'hFE, lat);
    check("adj_lat", lat, 1);
    check("adj_sp", {24'd0, sp}, 32'h0E);
    check("adj_nomem", log_addr.size(), 0);
    check("adj_rdata_held", {8'd0, rsp_rdata}, 32'h001234);

    // Length 0 behaves as length 1.
    run_cmd(2'd0, 2'd0, 24'hFFFF55, 8'h00, lat);
    check("push0_lat", lat, 2);
    check("push0_cnt", log_addr.size(), 1);
    chk_acc("push0", 0, 16'h010E, 1'b1, 8'h55);
    check("push0_sp", {24'd0, sp}, 32'h0D);

    run_cmd(2'd0, 2'd3, 24'hAABBCC, 8'h00, lat);
    check("push3_lat", lat, 4);
    chk_acc("push3", 0, 16'h010D, 1'b1, 8'hAA);
    chk_acc("push3", 2, 16'h010B, 1'b1, 8'hCC);
    check("push3_sp", {24'd0, sp}, 32'h0A);

    run_cmd(2'd1, 2'd3, 24'h0, 8'h00, lat);
    check("pull3_lat", lat, 7);
    check("pull3_rdata", {8'd0, rsp_rdata}, 32'hAABBCC);
    check("pull3_sp", {24'd0, sp}, 32'h0D);

    // Pull across FF -> 00 sets wrap; rdata is cleared on acceptance.
    run_cmd(2'd2, 2'd0, 24'h0, 8'hFF, lat);
    run_cmd(2'd1, 2'd1, 24'h0, 8'h00, lat);
    check("pullw_lat", lat, 3);
    chk_acc("pullw", 0, 16'h0100, 1'b0, 8'hAB);
    check("pullw_rdata", {8'd0, rsp_rdata}, 32'h0000AB);
    check("pullw_sp", {24'd0, sp}, 32'h00);
    check("pullw_wrap", {31'd0, wrap}, 32'd1);

    // Delayed ack: request must hold steady while waiting.
    run_cmd(2'd2, 2'd0, 24'h0, 8'hFF, lat);
    ack_delay = 3;
    stable_err = 0;
    run_cmd(2'd0, 2'd2, 24'h009988, 8'h00, lat);
    check("pushd_lat", lat, 9);
    check("pushd_stable", stable_err, 0);
    check("pushd_cnt", log_addr.size(), 2);
    chk_acc("pushd", 0, 16'h01FF, 1'b1, 8'h99);
    chk_acc("pushd", 1, 16'h01FE, 1'b1, 8'h88);
    check("pushd_sp", {24'd0, sp}, 32'hFD);

    // Reset while a push waits for its ack.
    ack_delay = 0;
    run_cmd(2'd2, 2'd0, 24'h0, 8'hFF, lat);
    ack_delay = 3;
    clear_log();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 2'd1; cmd_wdata = 24'h000077;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rstmid_req_before", {31'd0, mem_req}, 32'd1);
    check("rstmid_addr_before", {16'd0, mem_addr}, 32'h01FF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_req", {31'd0, mem_req}, 32'd0);
    check("rstmid_sp", {24'd0, sp}, 32'hFF);
    check("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    rst_n = 1'b1;
    ack_delay = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("rstmid_no_rsp", pulses, 0);
    check("rstmid_no_write", log_addr.size(), 0);
    check("rstmid_req_after", {31'd0, mem_req}, 32'd0);
    check("rstmid_sp_after", {24'd0, sp}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL provide parameter STACK_PAGE, default 8'h01, high address byte of every stack access.
REQ-002 SHALL provide parameter SP_RESET, default 8'hFF, stack pointer value after reset.
REQ-003 SHALL provide port clk  in  1  sole clock, rising edge.
REQ-004 SHALL provide port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL provide port cmd_valid  in  1  command request.
REQ-006 SHALL provide port cmd_ready  out  1  high when idle and able to accept a command.
REQ-007 SHALL provide port cmd_op  in  2  0=push, 1=pull, 2=load sp, 3=adjust sp by disp.
REQ-008 SHALL provide port cmd_len  in  2  byte count for push/pull, 1..3; 0 is treated as 1.
REQ-009 SHALL provide port cmd_wdata  in  24  push data, byte[i] = bits 8i+7:8i.
REQ-010 SHALL provide port cmd_disp  in  8  load value (op 2) or two's-complement displacement (op 3).
REQ-011 SHALL provide ports mem_req out 1, mem_we out 1, mem_addr out 16, mem_wdata out 8: stack memory request.
REQ-012 SHALL provide ports mem_ack in 1 and mem_rdata in 8: memory completion and read data, valid with mem_ack.
REQ-013 SHALL provide ports rsp_valid out 1 (one-cycle done pulse) and rsp_rdata out 24 (pulled bytes).
REQ-014 SHALL provide ports sp out 8 (current stack pointer) and wrap out 1 (sticky wrap flag).

Function
REQ-015 SHALL accept a command on a rising edge with cmd_valid and cmd_ready both high; all cmd_* fields are latched then.
REQ-016 SHALL implement states IDLE, PUSH, PULL_INC, PULL_RD, DONE; cmd_ready = 1 only in IDLE.
REQ-017 SHALL, on accepting a push, enter PUSH with byte index = len-1, so the highest byte is written first.
REQ-018 SHALL, in PUSH, drive mem_req=1, mem_we=1, mem_addr={STACK_PAGE,sp}, mem_wdata=byte[index].
REQ-019 SHALL, on mem_ack in PUSH, decrement sp mod 256; at index 0 go to DONE, otherwise decrement index and stay in PUSH.
REQ-020 SHALL, on accepting a pull, clear rsp_rdata, set byte index = 0, and enter PULL_INC.
REQ-021 SHALL, in PULL_INC, increment sp mod 256 in one cycle with no memory request, then enter PULL_RD.
REQ-022 SHALL, in PULL_RD, drive mem_req=1, mem_we=0, mem_addr={STACK_PAGE,sp}; on mem_ack, store mem_rdata into rsp_rdata byte[index].
REQ-023 SHALL, after the mem_ack that stores the last byte (index = len-1), enter DONE; otherwise increment index and return to PULL_INC.
REQ-024 SHALL, on accepting op 2, set sp = cmd_disp, clear wrap, and enter DONE.
REQ-025 SHALL, on accepting op 3, set sp = (sp + cmd_disp) mod 256, leave wrap unchanged, and enter DONE.
REQ-026 SHALL, in DONE, assert rsp_valid for exactly one cycle, then return to IDLE; rsp_rdata holds its value until the next pull is accepted.
REQ-027 SHALL hold mem_addr, mem_we and mem_wdata stable while mem_req is high and no mem_ack has arrived; mem_req is 0 outside PUSH and PULL_RD.
REQ-028 SHALL ignore mem_ack whenever mem_req is low.
REQ-029 SHALL set wrap when a push step decrements sp from 8'h00 to 8'hFF or a pull step increments sp from 8'hFF to 8'h00.
REQ-030 SHALL meet these latencies with mem_ack returned in the same cycle as mem_req: push of n bytes = n+1 cycles from acceptance to rsp_valid; pull of n bytes = 2n+1 cycles; load/adjust = 1 cycle.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously force state=IDLE, sp=SP_RESET, wrap=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, cmd_ready=1.
REQ-032 SHALL, if reset occurs mid-operation, abort the operation with no completion pulse, and drop mem_req immediately.

Verification
REQ-033 SHALL verify: release reset -> sp=8'hFF, cmd_ready=1, mem_req=0, wrap=0.
REQ-034 SHALL verify: push, len=2, wdata=24'h001234, immediate ack -> writes 0x01FF=12 then 0x01FE=34, sp=FD, rsp_valid 3 cycles after acceptance.
REQ-035 SHALL verify: pull, len=2, following REQ-034 with a memory model -> reads 0x01FE then 0x01FF, rsp_rdata=24'h001234, sp=FF.
REQ-036 SHALL verify: load disp=8'h00, then push len=1 -> write to 0x0100, sp=FF, wrap=1; a following load clears wrap.
REQ-037 SHALL verify: sp=8'h10, adjust disp=8'hFE -> sp=8'h0E, no memory request, rsp_valid pulse.
REQ-038 SHALL verify: push with mem_ack delayed 3 cycles -> request held stable throughout; rst_n low during the wait -> mem_req=0 at once, sp=FF, no rsp_valid.
